// File: rtl/wbi_sched_pkg.sv
// Shared types and constants for the four-master Wishbone-style scheduler.
// Holds the command FSM state encoding and the master count and index width.
package wbi_sched_pkg;

    localparam int NM = 4;
    localparam int MW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } sched_state_t;

endpackage

// File: rtl/wbi_rr_arb4.sv
// Four-way round-robin selector: picks the first requester after 'last'.
// Ports: req (requests), last (previous winner) -> gnt (winner index), any.
module wbi_rr_arb4
    import wbi_sched_pkg::*;
(
    input  logic [NM-1:0] req,
    input  logic [MW-1:0] last,
    output logic [MW-1:0] gnt,
    output logic          any
);

    logic [MW-1:0] w_idx;

    // Walk from lowest to highest priority so the nearest
    // requester after 'last' overwrites the others.
    always_comb begin
        gnt   = '0;
        w_idx = '0;
        for (int i = NM; i >= 1; i--) begin
            w_idx = last + MW'(i);
            if (req[w_idx]) gnt = w_idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/wbi_cmd_sched.sv
// Command scheduler: arbitrates four masters onto one daisy-chain command
// port (IDLE/HOLD/BURST FSM) and routes daisy-chain responses back by tid.
// Ports: mclk/reset_n, wbm_cmd_* (masters in), wbd_cmd_* (chain out),
// wbd_res_* (chain responses in), wbm_res_* (responses to masters).
module wbi_cmd_sched
    import wbi_sched_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4,
    parameter int BL = 10
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic [3:0]        wbm_cmd_wval_i,
    output logic [3:0]        wbm_cmd_wrdy_o,
    input  logic [4*AW-1:0]   wbm_cmd_adr_i,
    input  logic [3:0]        wbm_cmd_we_i,
    input  logic [4*DW-1:0]   wbm_cmd_dat_i,
    input  logic [4*BW-1:0]   wbm_cmd_sel_i,
    input  logic [15:0]       wbm_cmd_tid_i,
    input  logic [4*BL-1:0]   wbm_cmd_bl_i,
    input  logic [3:0]        wbm_res_rrdy_i,
    output logic [3:0]        wbm_res_rval_o,
    output logic [DW-1:0]     wbm_res_dat_o,
    output logic              wbm_res_ack_o,
    output logic              wbm_res_lack_o,
    output logic              wbm_res_err_o,
    output logic [3:0]        wbm_res_tid_o,
    input  logic              wbd_cmd_wrdy_i,
    output logic              wbd_cmd_wval_o,
    output logic [AW-1:0]     wbd_cmd_adr_o,
    output logic              wbd_cmd_we_o,
    output logic [DW-1:0]     wbd_cmd_dat_o,
    output logic [BW-1:0]     wbd_cmd_sel_o,
    output logic [3:0]        wbd_cmd_tid_o,
    output logic [BL-1:0]     wbd_cmd_bl_o,
    output logic              wbd_res_rrdy_o,
    input  logic              wbd_res_rval_i,
    input  logic [DW-1:0]     wbd_res_dat_i,
    input  logic              wbd_res_ack_i,
    input  logic              wbd_res_lack_i,
    input  logic              wbd_res_err_i,
    input  logic [3:0]        wbd_res_tid_i
);

    sched_state_t  r_state;
    sched_state_t  w_nstate;
    logic [MW-1:0] r_last;
    logic [MW-1:0] r_gnt;
    logic [BL-1:0] r_cnt;

    logic [MW-1:0] w_arb_gnt;
    logic          w_arb_any;
    logic [MW-1:0] w_gnt;
    logic          w_val;
    logic          w_hs;
    logic          w_first;
    logic          w_burst;
    logic [BL-1:0] w_bl;
    logic [MW-1:0] w_rix;
    logic          w_unused_tid;

    wbi_rr_arb4 u_arb (
        .req  (wbm_cmd_wval_i),
        .last (r_last),
        .gnt  (w_arb_gnt),
        .any  (w_arb_any)
    );

    // State register
    always_ff @(posedge mclk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nstate;
    end

    // Next-state logic
    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            IDLE, HOLD: begin
                if (w_hs)       w_nstate = w_burst ? BURST : IDLE;
                else if (w_val) w_nstate = HOLD;
            end
            BURST: begin
                if (w_hs && r_cnt == BL'(1)) w_nstate = IDLE;
            end
            default: w_nstate = IDLE;
        endcase
    end

    // Output logic: live arbitration in IDLE, frozen/locked grant otherwise
    always_comb begin
        w_gnt = w_arb_gnt;
        w_val = w_arb_any;
        unique case (r_state)
            IDLE: ;
            HOLD, BURST: begin
                w_gnt = r_gnt;
                w_val = wbm_cmd_wval_i[r_gnt];
            end
            default: ;
        endcase
    end

    assign w_hs    = w_val & wbd_cmd_wrdy_i;
    assign w_first = w_hs & (r_state != BURST);
    assign w_bl    = wbm_cmd_bl_i[BL*int'(w_gnt) +: BL];
    // bl of 0 or 1 is a single beat
    assign w_burst = wbm_cmd_we_i[w_gnt] & (w_bl > BL'(1));

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            r_last <= MW'(NM - 1);
            r_gnt  <= '0;
            r_cnt  <= '0;
        end else begin
            if (r_state != BURST) r_gnt <= w_gnt;
            if (w_first) begin
                r_last <= w_gnt;
                if (w_burst) r_cnt <= w_bl - BL'(1);
            end else if (w_hs) begin
                r_cnt <= r_cnt - BL'(1);
            end
        end
    end

    assign wbd_cmd_wval_o = w_val;
    assign wbd_cmd_adr_o  = wbm_cmd_adr_i[AW*int'(w_gnt) +: AW];
    assign wbd_cmd_we_o   = wbm_cmd_we_i[w_gnt];
    assign wbd_cmd_dat_o  = wbm_cmd_dat_i[DW*int'(w_gnt) +: DW];
    assign wbd_cmd_sel_o  = wbm_cmd_sel_i[BW*int'(w_gnt) +: BW];
    assign wbd_cmd_bl_o   = w_bl;
    // Upper tid bits carry the master index for response routing
    assign wbd_cmd_tid_o  = {w_gnt, wbm_cmd_tid_i[4*int'(w_gnt) +: 2]};
    assign wbm_cmd_wrdy_o = (wbd_cmd_wrdy_i & w_val) ? (4'b0001 << w_gnt)
                                                     : 4'b0000;

    assign w_unused_tid = ^{wbm_cmd_tid_i[15:14], wbm_cmd_tid_i[11:10],
                            wbm_cmd_tid_i[7:6], wbm_cmd_tid_i[3:2]};

    // Response path is independent of the command FSM
    assign w_rix          = wbd_res_tid_i[3:2];
    assign wbm_res_rval_o = wbd_res_rval_i ? (4'b0001 << w_rix) : 4'b0000;
    assign wbd_res_rrdy_o = wbm_res_rrdy_i[w_rix];
    assign wbm_res_dat_o  = wbd_res_dat_i;
    assign wbm_res_ack_o  = wbd_res_ack_i;
    assign wbm_res_lack_o = wbd_res_lack_i;
    assign wbm_res_err_o  = wbd_res_err_i;
    assign wbm_res_tid_o  = {2'b00, wbd_res_tid_i[1:0]};

endmodule

// File: doc/wbi_cmd_sched.md
WBI_CMD_SCHED -- requirements
Module: wbi_cmd_sched

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter BW, default 4: byte-enable width.
REQ-004 Parameter BL, default 10: burst-count width.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- mclk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- wbm_cmd_wval_i  in  4  per-master command valid.
- wbm_cmd_wrdy_o  out  4  per-master command ready.
- wbm_cmd_adr_i  in  4xAW  per-master address.
- wbm_cmd_we_i  in  4  per-master write.
- wbm_cmd_dat_i  in  4xDW  per-master write data.
- wbm_cmd_sel_i  in  4xBW  per-master byte enables.
- wbm_cmd_tid_i  in  4x4  per-master tid; bits [3:2] ignored.
- wbm_cmd_bl_i  in  4xBL  per-master burst count.
- wbm_res_rrdy_i  in  4  per-master response ready.
- wbm_res_rval_o  out  4  per-master response valid.
- wbm_res_dat_o / ack_o / lack_o / err_o / tid_o  out  DW/1/1/1/4  response payload, broadcast to all masters.
- wbd_cmd_wrdy_i  in  1  daisy-chain command ready.
- wbd_cmd_wval_o, adr_o, we_o, dat_o, sel_o, tid_o, bl_o  out  1/AW/1/DW/BW/4/BL  daisy-chain command.
- wbd_res_rrdy_o  out  1  daisy-chain response ready.
- wbd_res_rval_i, dat_i, ack_i, lack_i, err_i, tid_i  in  1/DW/1/1/1/4  daisy-chain response.

Function
REQ-006 A command handshake SHALL occur when wval and wrdy are both high in the same cycle.
REQ-007 The FSM SHALL have three states: IDLE, HOLD and BURST.
REQ-008 In IDLE with any wval high, the grant SHALL go to the first requester in round-robin order starting at last_winner+1 (mod 4); last_winner resets to 3, so master 0 has first priority.
REQ-009 The command path SHALL be combinational: wbd_cmd_* = granted master's fields, except wbd_cmd_tid_o = {grant[1:0], wbm_cmd_tid_i[g][1:0]}.
REQ-010 wbm_cmd_wrdy_o[g] SHALL equal wbd_cmd_wrdy_i for the granted master only; all other ready bits SHALL be 0.
REQ-011 If wbd_cmd_wval_o=1 and wbd_cmd_wrdy_i=0, the FSM SHALL go to HOLD, and the grant SHALL be frozen until the handshake, so the payload is never switched mid-offer.
REQ-012 On a handshake of a write with bl>1, the FSM SHALL go to BURST and load beat counter = bl-1.
REQ-013 On any other handshake, the FSM SHALL go to IDLE, and last_winner SHALL update to the granted master on every first-beat handshake.
REQ-014 bl=0 SHALL be treated as 1.
REQ-015 In BURST, only the locked master SHALL be granted; each handshake SHALL decrement the counter; the handshake at counter=1 SHALL return the FSM to IDLE.
REQ-016 In BURST, the locked master deasserting wval SHALL hold the lock; no other master is served.
REQ-017 Response routing SHALL be fully combinational, with index r = wbd_res_tid_i[3:2]:
- wbm_res_rval_o[r] = wbd_res_rval_i, other bits 0;
- wbd_res_rrdy_o = wbm_res_rrdy_i[r];
- wbm_res_tid_o = {2'b00, wbd_res_tid_i[1:0]}.
REQ-018 The response path SHALL be independent of the command FSM, so a response and a command handshake in the same cycle both proceed.
REQ-019 A new IDLE grant in a cycle SHALL be visible with zero latency; the block adds no pipeline stage.

Reset
REQ-020 While reset_n=0 at a mclk edge:
- FSM goes to IDLE;
- last_winner = 3;
- beat counter = 0;
- frozen grant cleared.
REQ-021 Reset mid-burst or mid-HOLD SHALL abandon the transaction with no further beats forwarded.
REQ-022 Outputs after reset SHALL be: wbd_cmd_wval_o=0 while all wbm_cmd_wval_i are 0, and wbm_cmd_wrdy_o=0.

Structure
REQ-023 Package wbi_sched_pkg SHALL hold the FSM state enum (IDLE, HOLD, BURST), constant NM=4 and master-index width MW=2.
REQ-024 The round-robin selector SHALL be a sub-module wbi_rr_arb4 (req[3:0], last[1:0] -> gnt[1:0], any).
REQ-025 The FSM, counter and muxes SHALL reside in wbi_cmd_sched.

Verification
REQ-026 Master 0 and master 2 read simultaneously with wrdy=1 -> master 0 forwarded in cycle 0 with tid 4'b00xx, master 2 in cycle 1 with tid 4'b10xx.
REQ-027 Master 1 writes with bl=4 while master 3 holds wval, with wrdy toggling 1,0,1,1,1 -> exactly 4 master-1 beats forwarded contiguously, then master 3 granted.
REQ-028 Master 2 offers a read with wrdy=0 for 3 cycles while master 0 raises wval in cycle 1 -> payload stays master 2 until the handshake in cycle 3.
REQ-029 A response arrives with tid=4'b1101 and wbm_res_rrdy_i=4'b1011 -> only wbm_res_rval_o[3]=1, wbd_res_rrdy_o=1, wbm_res_tid_o=4'b0001.
REQ-030 reset_n pulsed low after beat 2 of a bl=5 write -> after release the FSM is IDLE, master 0 has top priority, and no residual beats are forwarded.
REQ-031 All 4 masters request continuously with bl=1 -> grant order 0,1,2,3,0..., and each master gets 25% over 400 cycles.
